seq_shift_add_multiplier: RTL

//   Iterative shift-and-add multiplier, parametrised in operand width.
//   - One multiplier bit per clock; full-width 2*WIDTH product (no truncation).
//   - Optional two's-complement (signed) mode, selected per operation.
//   - valid/ready handshakes on both the operand side and the result side.
//   - Sits in the computation datapath where an area-cheap multiplier with

---
 rtl/seq_shift_add_multiplier.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one multiplier bit per clock,
// full 2*WIDTH product, optional two's-complement mode per operation.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] step;
  logic             neg;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;

  // -2^(WIDTH-1) negates to itself, which read unsigned is its magnitude
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (is_signed && a[WIDTH-1]) a_mag = -a;
    if (is_signed && b[WIDTH-1]) b_mag = -b;
  end

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (step == CNT_W'(WIDTH - 1));
  assign addend    = {{WIDTH{1'b0}}, mcand} << step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operands are only sampled on the accept edge, so X elsewhere is inert
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      step    <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        step   <= '0;
      end
      if (state == BUSY) begin
        if (mplier[0]) acc <= acc + addend;
        mplier <= mplier >> 1;
        step   <= step + 1'b1;
      end
      if (state == FIX) begin
        product <= neg ? -acc : acc;
      end
    end
  end

endmodule
